// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned BLOCK_W    = 128;

  typedef logic [0:BLOCK_W-1] aes_block_t;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_ctrl_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse is x^254 by square-and-multiply (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-buffer side handshakes: plaintext in, ciphertext out.
interface aes_round_ctrl_if;
  logic               in_valid;
  logic               in_ready;
  aes_pkg::aes_block_t plain_text;
  logic               out_valid;
  logic               out_ready;
  aes_pkg::aes_block_t cipher_text;

  modport ctrl (
    input  in_valid, plain_text, out_ready,
    output in_ready, out_valid, cipher_text
  );

  modport host (
    output in_valid, plain_text, out_ready,
    input  in_ready, out_valid, cipher_text
  );
endinterface

// File: rtl/aes_round.sv
// Combinational AES round: subBytes, shiftRows, optional mixColumns, addRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t round_in,
  input  aes_block_t round_key,
  input  logic       skip_mix,
  output aes_block_t round_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign sb[gi] = sbox(round_in[8*gi +: 8]);
    assign sr[gi] = sb[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    assign round_out[8*gi +: 8] = (skip_mix ? sr[gi] : mc[gi]) ^ round_key[8*gi +: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi + 0];
    assign a1 = sr[4*gi + 1];
    assign a2 = sr[4*gi + 2];
    assign a3 = sr[4*gi + 3];
    assign mc[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: owns the state register and round counter,
// fetches round keys by index and steps the external round datapath once per cycle.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  aes_round_ctrl_if.ctrl   bus,
  output logic [3:0]       key_index,
  input  aes_block_t       round_key,
  input  logic             key_valid,
  output aes_block_t       round_in,
  output logic             skip_mix,
  input  aes_block_t       round_out,
  output logic             busy
);

  aes_ctrl_state_t ctrl_reg, ctrl_next;
  logic [3:0]      round_cnt_reg, round_cnt_next;
  aes_block_t      state_reg, state_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ctrl_reg      <= IDLE;
      round_cnt_reg <= 4'd0;
      state_reg     <= '0;
    end else begin
      ctrl_reg      <= ctrl_next;
      round_cnt_reg <= round_cnt_next;
      state_reg     <= state_next;
    end
  end

  always_comb begin
    ctrl_next      = ctrl_reg;
    round_cnt_next = round_cnt_reg;
    state_next     = state_reg;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    busy           = 1'b1;
    skip_mix       = 1'b0;
    key_index      = 4'd0;

    // A low key_valid in ROUND/FINAL leaves every register untouched.
    case (ctrl_reg)
      IDLE: begin
        busy         = 1'b0;
        bus.in_ready = key_valid;
        if (bus.in_valid && key_valid) begin
          state_next     = bus.plain_text ^ round_key;
          round_cnt_next = 4'd1;
          ctrl_next      = ROUND;
        end
      end
      ROUND: begin
        key_index = round_cnt_reg;
        if (key_valid) begin
          state_next     = round_out;
          round_cnt_next = round_cnt_reg + 4'd1;
          if (round_cnt_reg == 4'(NUM_ROUNDS - 1)) ctrl_next = FINAL;
        end
      end
      FINAL: begin
        key_index = 4'(NUM_ROUNDS);
        skip_mix  = 1'b1;
        if (key_valid) begin
          state_next = round_out;
          ctrl_next  = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          round_cnt_next = 4'd0;
          ctrl_next      = IDLE;
        end
      end
      default: begin
        round_cnt_next = 4'd0;
        ctrl_next      = IDLE;
      end
    endcase
  end

  assign round_in        = state_reg;
  assign bus.cipher_text = state_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl wired to aes_round, using FIPS-197 vectors.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk;
  logic       n_rst;
  logic [3:0] key_index;
  aes_block_t round_key;
  logic       key_valid;
  aes_block_t round_in;
  logic       skip_mix;
  aes_block_t round_out;
  logic       busy;

  aes_round_ctrl_if bus();

  aes_round_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .key_index (key_index),
    .round_key (round_key),
    .key_valid (key_valid),
    .round_in  (round_in),
    .skip_mix  (skip_mix),
    .round_out (round_out),
    .busy      (busy)
  );

  aes_round u_dp (
    .round_in  (round_in),
    .round_key (round_key),
    .skip_mix  (skip_mix),
    .round_out (round_out)
  );

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R1_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int checks = 0;
  int errors = 0;

  logic [127:0] rk [0:10];

  assign round_key = (key_index <= 4'd10) ? rk[key_index] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Brute-force inverse search keeps this independent of the RTL S-box.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]) ^ rc, tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called just after a falling edge with the controller idle; returns after
  // the output handshake, again just after a falling edge.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int stall_r4, input int stall_fin, input int hold,
                           input int exp_lat, input logic chk_first);
    int         lat, r4_left, fin_left, skips;
    logic       stalled, done;
    logic [3:0] snap_ki;
    aes_block_t snap_ri;
    bus.plain_text = pt;
    bus.in_valid   = 1'b1;
    key_valid      = 1'b1;
    #1 check_eq("accept_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.plain_text = '0;
    lat = 0; r4_left = stall_r4; fin_left = stall_fin; skips = 0;
    stalled = 1'b0; done = 1'b0; snap_ki = 4'd0; snap_ri = '0;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (stalled) begin
        check_eq("stall_key_index", 128'(key_index), 128'(snap_ki));
        check_eq("stall_state", round_in, snap_ri);
      end
      if (lat == 0 && chk_first) check_eq("round1_in", round_in, R1_B);
      if (bus.out_valid) begin
        done = 1'b1;
      end else begin
        if (skip_mix) skips++;
        stalled = 1'b1;
        if (key_index == 4'd4 && !skip_mix && r4_left > 0) begin
          key_valid = 1'b0; r4_left--;
        end else if (skip_mix && fin_left > 0) begin
          key_valid = 1'b0; fin_left--;
        end else begin
          key_valid = 1'b1; stalled = 1'b0;
        end
        snap_ki = key_index;
        snap_ri = round_in;
        @(posedge clk);
        lat++;
      end
    end
    key_valid = 1'b1;
    check_eq("latency", 128'(lat), 128'(exp_lat));
    check_eq("cipher_text", bus.cipher_text, exp_ct);
    check_eq("skip_mix_cycles", 128'(skips), 128'(1 + stall_fin));
    check_eq("busy_done", 128'(busy), 128'd1);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_out_valid", 128'(bus.out_valid), 128'd1);
      check_eq("hold_cipher", bus.cipher_text, exp_ct);
      check_eq("hold_in_ready", 128'(bus.in_ready), 128'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_in_ready", 128'(bus.in_ready), 128'd1);
    check_eq("post_hs_out_valid", 128'(bus.out_valid), 128'd0);
    $display("block pt=%h ct=%h lat=%0d", pt, bus.cipher_text, lat);
  endtask

  initial begin
    int n_out;
    n_rst          = 1'b1;
    key_valid      = 1'b1;
    bus.in_valid   = 1'b0;
    bus.plain_text = '0;
    bus.out_ready  = 1'b0;
    expand_key(KEY_B);
    #2 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_skip_mix", 128'(skip_mix), 128'd0);
    check_eq("rst_key_index", 128'(key_index), 128'd0);
    check_eq("rst_cipher", bus.cipher_text, 128'd0);
    n_rst = 1'b1;
    @(negedge clk);

    run_block(PT_B, CT_B, 0, 0, 0, 10, 1'b1);
    run_block(PT_B, CT_B, 3, 2, 5, 15, 1'b1);

    // Abandon a block mid-flight with an asynchronous reset.
    bus.plain_text = PT_B;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && key_index != 4'd5; i++) @(negedge clk);
    check_eq("reach_round5", 128'(key_index), 128'd5);
    n_rst = 1'b0;
    #1;
    check_eq("midrst_busy", 128'(busy), 128'd0);
    check_eq("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("midrst_key_index", 128'(key_index), 128'd0);
    check_eq("midrst_state", round_in, 128'd0);
    check_eq("midrst_in_ready", 128'(bus.in_ready), 128'd1);
    @(negedge clk);
    n_rst = 1'b1;
    n_out = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid || busy) n_out++;
    end
    check_eq("no_activity_after_rst", 128'(n_out), 128'd0);
    run_block(PT_B, CT_B, 0, 0, 0, 10, 1'b1);

    // Back-to-back: second block accepted the cycle after the handshake.
    run_block(PT_B, CT_B, 0, 0, 0, 10, 1'b1);
    expand_key(128'd0);
    run_block(128'd0, CT_Z, 0, 0, 0, 10, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
